mips32_trace_capture: RTL and testbench



---
 rtl/mips32_trace_pkg.sv | 18 +
 rtl/mips32_trace_ram.sv | 23 ++
 rtl/mips32_trace_capture.sv | 135 +++++++++++++
 tb/tb_mips32_trace_capture.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_trace_pkg.sv
// Shared mode/state encodings and width helper for the MIPS32 trace capture unit.
package mips32_trace_pkg;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_CONT    = 2'd1;
  localparam logic [1:0] MODE_TRIG    = 2'd2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Entry count must represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mips32_trace_ram.sv
// Trace storage: DEPTH x 2*DATA_W, synchronous write, asynchronous read, no reset.
module mips32_trace_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [2*DATA_W-1:0] wdata,
  input  logic [AW-1:0]       raddr,
  output logic [2*DATA_W-1:0] rdata
);

  logic [2*DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips32_trace_capture.sv
// Records (instr, result) pairs into a circular buffer and streams them oldest-first on a valid/ready port.
// Writes land on the capturing edge; rd_valid rises the cycle DONE is entered and data holds while rd_ready is low.
module mips32_trace_capture
  import mips32_trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int POST   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_valid,
  input  logic [DATA_W-1:0] cap_instr,
  input  logic [DATA_W-1:0] cap_result,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [DATA_W-1:0] trig_value,
  input  logic              arm,
  input  logic              stop,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_instr,
  output logic [DATA_W-1:0] rd_result,
  output logic              rd_last,
  output logic [$clog2(DEPTH):0] count,
  output logic              busy,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] POST_C = CW'(POST);

  logic [1:0]          state, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [AW-1:0]       wptr, wptr_d, rd_ptr, rd_ptr_d;
  logic [CW-1:0]       count_d;
  logic                ovf_d;
  logic                we;
  logic                hit;
  logic [2*DATA_W-1:0] rdata;

  assign hit = (cap_instr & trig_mask) == (trig_value & trig_mask);

  always_comb begin
    state_d  = state;
    mode_d   = mode_q;
    wptr_d   = wptr;
    rd_ptr_d = rd_ptr;
    count_d  = count;
    ovf_d    = overflow;
    we       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arm) begin
          mode_d  = (mode == MODE_CONT || mode == MODE_TRIG) ? mode : MODE_ONESHOT;
          wptr_d  = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = (mode == MODE_TRIG) ? ST_ARMED : ST_CAPTURE;
        end
      end
      ST_ARMED: begin
        if (cap_valid && hit) begin
          we      = 1'b1;
          wptr_d  = wptr + 1'b1;
          count_d = CW'(1);
          state_d = (POST == 1 || stop) ? ST_DONE : ST_CAPTURE;
        end else if (stop) begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (cap_valid) begin
          we     = 1'b1;
          wptr_d = wptr + 1'b1;
          // CONT keeps overwriting the oldest entry once the buffer is full.
          if (mode_q == MODE_CONT && count == FULL_C) ovf_d = 1'b1;
          else count_d = count + 1'b1;
        end
        case (mode_q)
          MODE_CONT: if (stop) state_d = ST_DONE;
          MODE_TRIG: if (stop || count_d == POST_C) state_d = ST_DONE;
          default:   if (count_d == FULL_C) state_d = ST_DONE;
        endcase
      end
      default: begin
        if (count == '0) begin
          state_d = ST_IDLE;
        end else if (rd_ready) begin
          rd_ptr_d = rd_ptr + 1'b1;
          count_d  = count - 1'b1;
          if (count == CW'(1)) state_d = ST_IDLE;
        end
      end
    endcase
    // Oldest entry sits count slots behind the write pointer; modulo wrap is free at power-of-two depth.
    if (state != ST_DONE && state_d == ST_DONE) rd_ptr_d = wptr_d - count_d[AW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      mode_q   <= MODE_ONESHOT;
      wptr     <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_d;
      mode_q   <= mode_d;
      wptr     <= wptr_d;
      rd_ptr   <= rd_ptr_d;
      count    <= count_d;
      overflow <= ovf_d;
    end
  end

  mips32_trace_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wptr),
    .wdata ({cap_instr, cap_result}),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign rd_valid  = (state == ST_DONE) && (count != '0);
  assign rd_instr  = rd_valid ? rdata[2*DATA_W-1:DATA_W] : '0;
  assign rd_result = rd_valid ? rdata[DATA_W-1:0] : '0;
  assign rd_last   = rd_valid && (count == CW'(1));
  assign busy      = (state == ST_ARMED) || (state == ST_CAPTURE);

endmodule

// File: tb/tb_mips32_trace_capture.sv
// Randomized scoreboard bench for mips32_trace_capture (DEPTH=4, POST=3).
module tb_mips32_trace_capture;
  import mips32_trace_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int POST  = 3;
  localparam logic [31:0] TMASK = 32'hFC00_0000;
  localparam logic [31:0] TVAL  = 32'h8C00_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cap_valid, arm, stop, rd_ready;
  logic [DW-1:0] cap_instr, cap_result, trig_mask, trig_value;
  logic [1:0]    mode;
  logic          rd_valid, rd_last, busy, overflow;
  logic [DW-1:0] rd_instr, rd_result;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  mips32_trace_capture #(.DATA_W(DW), .DEPTH(DEPTH), .POST(POST)) dut (
    .clk(clk), .rst_n(rst_n), .cap_valid(cap_valid), .cap_instr(cap_instr),
    .cap_result(cap_result), .mode(mode), .trig_mask(trig_mask), .trig_value(trig_value),
    .arm(arm), .stop(stop), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_instr(rd_instr),
    .rd_result(rd_result), .rd_last(rd_last), .count(count), .busy(busy), .overflow(overflow)
  );

  typedef struct packed {
    logic [31:0] i;
    logic [31:0] r;
  } ent_t;

  ent_t stim[$];
  ent_t exp_q[$];
  bit   exp_ovf;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the set of entries a session must yield, derived from the sample list alone.
  task automatic session(input logic [1:0] m, input int stop_at, input bit stop_sep, input bit gaps);
    ent_t sel[$];
    int f;
    logic [1:0] mm;
    mm = (m == MODE_CONT || m == MODE_TRIG) ? m : MODE_ONESHOT;
    exp_ovf = 1'b0;
    f = -1;
    if (mm == MODE_ONESHOT) begin
      foreach (stim[k]) if (sel.size() < DEPTH) sel.push_back(stim[k]);
    end else if (mm == MODE_CONT) begin
      foreach (stim[k]) if (stop_at < 0 || k <= stop_at) sel.push_back(stim[k]);
      exp_ovf = sel.size() > DEPTH;
      while (sel.size() > DEPTH) void'(sel.pop_front());
    end else begin
      foreach (stim[k]) if (f < 0 && (stim[k].i & TMASK) == (TVAL & TMASK)) f = k;
      if (f >= 0)
        for (int k = f; k < stim.size() && sel.size() < POST; k++) sel.push_back(stim[k]);
    end
    foreach (sel[k]) exp_q.push_back(sel[k]);

    trig_mask = TMASK; trig_value = TVAL; mode = m; arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("busy_after_arm", 64'(busy), 64'd1);
    foreach (stim[k]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        cap_valid = 1'b0;
        tick();
      end
      cap_valid = 1'b1; cap_instr = stim[k].i; cap_result = stim[k].r; stop = (k == stop_at);
      tick();
    end
    cap_valid = 1'b0; stop = 1'b0; cap_instr = '0; cap_result = '0;
    if (stop_sep) begin
      stop = 1'b1;
      tick();
      stop = 1'b0;
    end
    chk("count_after_capture", 64'(count), 64'(exp_q.size()));
    chk("overflow_after_capture", 64'(overflow), 64'(exp_ovf));
  endtask

  task automatic drain();
    int c;
    for (c = 0; c < 200; c++) begin
      if (exp_q.size() == 0 && !rd_valid) break;
      rd_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    rd_ready = 1'b0;
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_valid_low", 64'(rd_valid), 64'd0);
    chk("drain_busy_low", 64'(busy), 64'd0);
    chk("drain_overflow_held", 64'(overflow), 64'(exp_ovf));
  endtask

  // Monitor: pops the scoreboard on each accepted entry and checks hold under backpressure.
  bit          stall_prev = 1'b0;
  logic [31:0] held_i, held_r;
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else if (rd_valid) begin
        if (stall_prev) begin
          chk("hold_instr", 64'(rd_instr), 64'(held_i));
          chk("hold_result", 64'(rd_result), 64'(held_r));
        end
        chk("count_vs_model", 64'(count), 64'(exp_q.size()));
        chk("rd_last", 64'(rd_last), 64'(exp_q.size() == 1));
        if (rd_ready) begin
          stall_prev = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_entry", 64'(rd_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rd_instr", 64'(rd_instr), 64'(e.i));
            chk("rd_result", 64'(rd_result), 64'(e.r));
          end
        end else begin
          stall_prev = 1'b1;
          held_i = rd_instr;
          held_r = rd_result;
        end
      end else begin
        stall_prev = 1'b0;
        chk("idle_outputs_zero", {31'd0, rd_last, rd_instr}, 64'd0);
        chk("idle_result_zero", 64'(rd_result), 64'd0);
      end
    end
  end

  initial begin
    ent_t en;
    logic [1:0] m;
    int n;
    rst_n = 1'b0; cap_valid = 1'b0; arm = 1'b0; stop = 1'b0; rd_ready = 1'b0;
    cap_instr = '0; cap_result = '0; mode = '0; trig_mask = '0; trig_value = '0;
    #2;
    chk("reset_valid", 64'(rd_valid), 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    chk("reset_data", {rd_instr, rd_result}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // One-shot keeps the first DEPTH samples; then backpressure check.
    stim.delete();
    for (int k = 0; k < 6; k++) begin en.i = 32'(k + 1); en.r = 32'hA000_0000 | 32'(k); stim.push_back(en); end
    session(MODE_ONESHOT, -1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_count", 64'(count), 64'd4);
      chk("bp_instr", 64'(rd_instr), 64'h1);
    end
    rd_ready = 1'b1;
    tick();
    chk("bp_next_instr", 64'(rd_instr), 64'h2);
    chk("bp_next_count", 64'(count), 64'd3);
    drain();

    // Continuous with overflow, stop on last sample.
    session(MODE_CONT, 5, 1'b0, 1'b0);
    drain();

    // Trigger: first matching opcode starts a POST-long window.
    stim.delete();
    en.r = 32'h11; en.i = 32'h0000_0020;    stim.push_back(en);
    en.r = 32'h22; en.i = 32'h8C01_0004;    stim.push_back(en);
    en.r = 32'h33; en.i = 32'h1;            stim.push_back(en);
    en.r = 32'h44; en.i = 32'h2;            stim.push_back(en);
    en.r = 32'h55; en.i = 32'h3;            stim.push_back(en);
    session(MODE_TRIG, -1, 1'b1, 1'b0);
    drain();

    // stop together with the third sample in continuous mode.
    stim.delete();
    for (int k = 0; k < 3; k++) begin en.i = 32'h100 + 32'(k); en.r = 32'h200 + 32'(k); stim.push_back(en); end
    session(MODE_CONT, 2, 1'b0, 1'b0);
    drain();

    // stop while still waiting for the trigger.
    stim.delete();
    en.i = 32'h0000_0020; en.r = 32'h7; stim.push_back(en);
    session(MODE_TRIG, -1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    drain();

    // Reset in the middle of a readout.
    stim.delete();
    for (int k = 0; k < 6; k++) begin en.i = 32'(k + 1); en.r = 32'(k + 9); stim.push_back(en); end
    session(MODE_CONT, -1, 1'b1, 1'b0);
    rd_ready = 1'b1;
    tick(); tick();
    rd_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(rd_valid), 64'd0);
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_overflow", 64'(overflow), 64'd0);
    chk("midrst_data", {rd_instr, rd_result}, 64'd0);
    exp_q.delete();
    exp_ovf = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    session(MODE_ONESHOT, -1, 1'b0, 1'b0);
    drain();

    // Randomized sessions across all mode codes.
    for (int s = 0; s < 40; s++) begin
      m = 2'($urandom_range(0, 3));
      n = (m == MODE_CONT || m == MODE_TRIG) ? int'($urandom_range(1, 9)) : int'($urandom_range(DEPTH, DEPTH + 4));
      stim.delete();
      for (int k = 0; k < n; k++) begin
        en.i = (m == MODE_TRIG && $urandom_range(0, 2) == 0) ? {6'h23, 26'($urandom)} : 32'($urandom);
        en.r = 32'($urandom);
        stim.push_back(en);
      end
      if (m == MODE_CONT) begin
        if ($urandom_range(0, 1) == 1) session(m, n - 1, 1'b0, 1'b1);
        else session(m, -1, 1'b1, 1'b1);
      end else if (m == MODE_TRIG) begin
        session(m, -1, 1'b1, 1'b1);
      end else begin
        session(m, -1, 1'b0, 1'b1);
      end
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
